leta_poll_ctrl: RTL and testbench

//  Sequences reads of the LETA trackball counter chip: on each frame tick walks the LETA

---
 rtl/leta_poll_ctrl_if.sv | 32 +++
 rtl/leta_poll_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_leta_poll_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/leta_poll_ctrl_if.sv
// Result bus from leta_poll_ctrl to the cursor/frame-buffer writer (valid/ready).
// Optional P2 fields are present when LETA_P2_EN is defined.
interface leta_poll_ctrl_if;
  logic        pos_valid;
  logic        pos_ready;
  logic [10:0] pos_x;
  logic [9:0]  pos_y;
  logic [7:0]  delta_x;
  logic [7:0]  delta_y;
`ifdef LETA_P2_EN
  logic [10:0] pos2_x;
  logic [9:0]  pos2_y;
  logic [7:0]  delta2_x;
  logic [7:0]  delta2_y;
`endif

  modport master (
`ifdef LETA_P2_EN
    output pos2_x, pos2_y, delta2_x, delta2_y,
`endif
    output pos_valid, pos_x, pos_y, delta_x, delta_y,
    input  pos_ready
  );

  modport slave (
`ifdef LETA_P2_EN
    input  pos2_x, pos2_y, delta2_x, delta2_y,
`endif
    input  pos_valid, pos_x, pos_y, delta_x, delta_y,
    output pos_ready
  );
endinterface

// File: rtl/leta_poll_ctrl.sv
// LETA trackball poller: walks LETA addresses per frame tick, turns counts into signed
// deltas and a clamped cursor position. Define LETA_P2_EN to also poll player 2.
module leta_poll_ctrl #(
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned X_MAX   = 1279,
  parameter int unsigned Y_MAX   = 1023,
  parameter int unsigned X_SHIFT = 3,
  parameter int unsigned Y_SHIFT = 2
) (
  input  logic             GCLK,
  input  logic             reset,
  input  logic             ck_en,
  input  logic             tick,
  output logic [1:0]       leta_ad,
  input  logic [7:0]       leta_db,
  output logic             busy,
  output logic             overrun,
  leta_poll_ctrl_if.master pos_if
);

`ifdef LETA_P2_EN
  localparam int unsigned N_CH = 4;
  localparam int unsigned CH_W = 2;
`else
  localparam int unsigned N_CH = 2;
  localparam int unsigned CH_W = 1;
`endif
  localparam int unsigned CNT_W = $clog2(SETTLE + 1);
  localparam logic [10:0] X_CTR = 11'(X_MAX / 2);
  localparam logic [9:0]  Y_CTR = 10'(Y_MAX / 2);

  typedef enum logic [2:0] {
    S_IDLE, S_SETADR, S_SETTLE, S_SAMPLE, S_UPDATE
  } state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CH_W-1:0]   ad_q, ad_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pending_q, pending_d;
  logic              primed_q, primed_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic [7:0]        raw_q [N_CH];
  logic [7:0]        raw_d [N_CH];
  logic [7:0]        prev_q [N_CH];
  logic [7:0]        prev_d [N_CH];
  logic [7:0]        diff_c [N_CH];
  logic [10:0]       pos_x_q, pos_x_d;
  logic [9:0]        pos_y_q, pos_y_d;
  logic [7:0]        dx_q, dx_d, dy_q, dy_d;
`ifdef LETA_P2_EN
  logic [10:0]       pos2_x_q, pos2_x_d;
  logic [9:0]        pos2_y_q, pos2_y_d;
  logic [7:0]        dx2_q, dx2_d, dy2_q, dy2_d;
`endif

  logic start_c, last_ch_c, settle_done_c;

  assign start_c       = ck_en & (pending_q | tick);
  assign last_ch_c     = (ch_q == CH_W'(N_CH - 1));
  assign settle_done_c = (cnt_q == CNT_W'(1));

  // Signed, shifted accumulation evaluated at 13 bits, then clamped to [0, maxv].
  function automatic logic [10:0] step_pos(input logic [10:0] pos, input logic [7:0] d,
                                           input int unsigned sh, input int unsigned maxv);
    logic signed [12:0] sum;
    sum = $signed({2'b00, pos}) + ($signed({{5{d[7]}}, d}) <<< sh);
    if (sum[12])                        return 11'd0;
    else if (sum > $signed(13'(maxv)))  return 11'(maxv);
    else                                return sum[10:0];
  endfunction

  // State register
  always_ff @(posedge GCLK) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start_c)                 state_d = S_SETADR;
      S_SETADR: if (ck_en)                   state_d = S_SETTLE;
      S_SETTLE: if (ck_en && settle_done_c)  state_d = S_SAMPLE;
      S_SAMPLE: if (ck_en)                   state_d = last_ch_c ? S_UPDATE : S_SETADR;
      S_UPDATE:                              state_d = S_IDLE;
      default:                               state_d = S_IDLE;
    endcase
  end

  // Wrap-safe count differences
  always_comb begin
    for (int c = 0; c < N_CH; c++) diff_c[c] = raw_q[c] - prev_q[c];
  end

  // Datapath and output next values
  always_comb begin
    ch_d      = ch_q;
    ad_d      = ad_q;
    cnt_d     = cnt_q;
    primed_d  = primed_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    raw_d     = raw_q;
    prev_d    = prev_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
`ifdef LETA_P2_EN
    pos2_x_d  = pos2_x_q;
    pos2_y_d  = pos2_y_q;
    dx2_d     = dx2_q;
    dy2_d     = dy2_q;
`endif
    busy_d    = (state_d != S_IDLE);

    // One pending tick is remembered; further ticks before the round starts are dropped.
    pending_d = pending_q;
    if (state_q == S_IDLE && start_c) pending_d = 1'b0;
    else if (tick)                    pending_d = 1'b1;

    if (valid_q && pos_if.pos_ready) valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: if (start_c) ch_d = '0;
      S_SETADR: if (ck_en) begin
        ad_d  = ch_q;
        cnt_d = CNT_W'(SETTLE);
      end
      S_SETTLE: if (ck_en) cnt_d = cnt_q - CNT_W'(1);
      S_SAMPLE: if (ck_en) begin
        raw_d[ch_q] = leta_db;
        if (!last_ch_c) ch_d = ch_q + CH_W'(1);
      end
      S_UPDATE: begin
        prev_d   = raw_q;
        primed_d = 1'b1;
        // New data always wins; overrun only when the old result was never taken.
        if (valid_q && !pos_if.pos_ready) overrun_d = 1'b1;
        valid_d  = 1'b1;
        if (primed_q) begin
          dx_d    = diff_c[0];
          dy_d    = diff_c[1];
          pos_x_d = step_pos(pos_x_q, diff_c[0], X_SHIFT, X_MAX);
          pos_y_d = 10'(step_pos({1'b0, pos_y_q}, diff_c[1], Y_SHIFT, Y_MAX));
`ifdef LETA_P2_EN
          dx2_d    = diff_c[2];
          dy2_d    = diff_c[3];
          pos2_x_d = step_pos(pos2_x_q, diff_c[2], X_SHIFT, X_MAX);
          pos2_y_d = 10'(step_pos({1'b0, pos2_y_q}, diff_c[3], Y_SHIFT, Y_MAX));
`endif
        end else begin
          dx_d = '0;
          dy_d = '0;
`ifdef LETA_P2_EN
          dx2_d = '0;
          dy2_d = '0;
`endif
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge GCLK) begin
    if (reset) begin
      ch_q      <= '0;
      ad_q      <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      primed_q  <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        raw_q[c]  <= '0;
        prev_q[c] <= '0;
      end
      pos_x_q   <= X_CTR;
      pos_y_q   <= Y_CTR;
      dx_q      <= '0;
      dy_q      <= '0;
`ifdef LETA_P2_EN
      pos2_x_q  <= X_CTR;
      pos2_y_q  <= Y_CTR;
      dx2_q     <= '0;
      dy2_q     <= '0;
`endif
    end else begin
      ch_q      <= ch_d;
      ad_q      <= ad_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      primed_q  <= primed_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      raw_q     <= raw_d;
      prev_q    <= prev_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
`ifdef LETA_P2_EN
      pos2_x_q  <= pos2_x_d;
      pos2_y_q  <= pos2_y_d;
      dx2_q     <= dx2_d;
      dy2_q     <= dy2_d;
`endif
    end
  end

  assign leta_ad          = 2'(ad_q);
  assign busy             = busy_q;
  assign overrun          = overrun_q;
  assign pos_if.pos_valid = valid_q;
  assign pos_if.pos_x     = pos_x_q;
  assign pos_if.pos_y     = pos_y_q;
  assign pos_if.delta_x   = dx_q;
  assign pos_if.delta_y   = dy_q;
`ifdef LETA_P2_EN
  assign pos_if.pos2_x    = pos2_x_q;
  assign pos_if.pos2_y    = pos2_y_q;
  assign pos_if.delta2_x  = dx2_q;
  assign pos_if.delta2_y  = dy2_q;
`endif

endmodule

// File: tb/tb_leta_poll_ctrl.sv
// Directed bench for leta_poll_ctrl: table of poll rounds plus overrun and
// mid-round reset sequences.
module tb_leta_poll_ctrl;
  logic       GCLK = 1'b0;
  logic       reset = 1'b1;
  logic       ck_en = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] leta_ad;
  logic [7:0] leta_db;
  logic       busy;
  logic       overrun;
  logic [7:0] chip [4];
  int         ck_div = 0;
  int         n_total = 0;
  int         n_pass = 0;

  leta_poll_ctrl_if pos_if ();

  leta_poll_ctrl dut (
    .GCLK    (GCLK),
    .reset   (reset),
    .ck_en   (ck_en),
    .tick    (tick),
    .leta_ad (leta_ad),
    .leta_db (leta_db),
    .busy    (busy),
    .overrun (overrun),
    .pos_if  (pos_if)
  );

  always #5 GCLK = ~GCLK;

  // LETA CK enable: one GCLK in three
  always @(negedge GCLK) begin
    ck_div = (ck_div == 2) ? 0 : ck_div + 1;
    ck_en  = (ck_div == 0);
  end

  // Counter chip model answers whatever address is driven
  assign leta_db = chip[leta_ad];

  typedef struct {
    logic [7:0] cx;
    logic [7:0] cy;
    logic [7:0] dx;
    logic [7:0] dy;
    int         px;
    int         py;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic logic probe(input int which);
    case (which)
      0:       return busy;
      1:       return leta_ad == 2'd0;
      2:       return leta_ad == 2'd1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int which, input logic val, input string nm);
    int n = 0;
    while (probe(which) !== val && n < 300) begin
      @(posedge GCLK); #1;
      n++;
    end
    chk(nm, int'(n < 300), 1);
  endtask

  task automatic run_round(input logic [7:0] cx, input logic [7:0] cy);
    @(negedge GCLK);
    chip[0] = cx;
    chip[1] = cy;
    tick = 1'b1;
    @(negedge GCLK);
    tick = 1'b0;
    wait_for(0, 1'b1, "busy_rise");
    wait_for(0, 1'b0, "busy_fall");
  endtask

  task automatic accept(input string nm);
    @(negedge GCLK);
    pos_if.pos_ready = 1'b1;
    @(posedge GCLK); #1;
    chk(nm, int'(pos_if.pos_valid), 0);
    @(negedge GCLK);
    pos_if.pos_ready = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"},  int'(busy), 0);
    chk({tag, "_valid"}, int'(pos_if.pos_valid), 0);
    chk({tag, "_ovr"},   int'(overrun), 0);
    chk({tag, "_ad"},    int'(leta_ad), 0);
    chk({tag, "_px"},    int'(pos_if.pos_x), 639);
    chk({tag, "_py"},    int'(pos_if.pos_y), 511);
    chk({tag, "_dx"},    int'(pos_if.delta_x), 0);
    chk({tag, "_dy"},    int'(pos_if.delta_y), 0);
  endtask

  initial begin
    vecs[0]  = '{8'h10, 8'h10, 8'h00, 8'h00,  639,  511};
    vecs[1]  = '{8'h15, 8'h0E, 8'h05, 8'hFE,  679,  503};
    vecs[2]  = '{8'hFE, 8'h0E, 8'hE9, 8'h00,  495,  503};
    vecs[3]  = '{8'h03, 8'h0E, 8'h05, 8'h00,  535,  503};
    vecs[4]  = '{8'hFE, 8'h0E, 8'hFB, 8'h00,  495,  503};
    vecs[5]  = '{8'h7D, 8'h90, 8'h7F, 8'h82, 1279,    0};
    vecs[6]  = '{8'h87, 8'h8D, 8'h0A, 8'hFD, 1279,    0};
    vecs[7]  = '{8'h82, 8'h0C, 8'hFB, 8'h7F, 1239,  508};
    vecs[8]  = '{8'h02, 8'h8B, 8'h80, 8'h7F,  215, 1016};
    vecs[9]  = '{8'h02, 8'h8D, 8'h00, 8'h02,  215, 1023};
    vecs[10] = '{8'h82, 8'h8D, 8'h80, 8'h00,    0, 1023};

    for (int i = 0; i < 4; i++) chip[i] = 8'h00;
    pos_if.pos_ready = 1'b0;

    repeat (3) @(posedge GCLK);
    @(negedge GCLK);
    reset = 1'b0;
    @(posedge GCLK); #1;
    chk_reset_state("reset");

    for (int i = 0; i < 11; i++) begin
      run_round(vecs[i].cx, vecs[i].cy);
      chk($sformatf("v%0d_valid", i), int'(pos_if.pos_valid), 1);
      chk($sformatf("v%0d_dx", i),    int'(pos_if.delta_x), int'(vecs[i].dx));
      chk($sformatf("v%0d_dy", i),    int'(pos_if.delta_y), int'(vecs[i].dy));
      chk($sformatf("v%0d_px", i),    int'(pos_if.pos_x), vecs[i].px);
      chk($sformatf("v%0d_py", i),    int'(pos_if.pos_y), vecs[i].py);
      chk($sformatf("v%0d_ovr", i),   int'(overrun), 0);
      accept($sformatf("v%0d_drop", i));
    end

    // Two rounds without acceptance: second result shown, overrun sticks
    run_round(8'h83, 8'h8D);
    chk("ovr1_dx", int'(pos_if.delta_x), 1);
    chk("ovr1_px", int'(pos_if.pos_x), 8);
    chk("ovr1_ovr", int'(overrun), 0);
    run_round(8'h85, 8'h8D);
    chk("ovr2_valid", int'(pos_if.pos_valid), 1);
    chk("ovr2_ovr", int'(overrun), 1);
    chk("ovr2_dx", int'(pos_if.delta_x), 2);
    chk("ovr2_px", int'(pos_if.pos_x), 24);
    chk("ovr2_py", int'(pos_if.pos_y), 1023);
    accept("ovr_drop");
    chk("ovr_sticky", int'(overrun), 1);

    // Reset while settling on channel 1 discards the round and unprimes
    @(negedge GCLK);
    chip[0] = 8'h55;
    chip[1] = 8'h66;
    tick = 1'b1;
    @(negedge GCLK);
    tick = 1'b0;
    wait_for(0, 1'b1, "mr_busy");
    wait_for(1, 1'b1, "mr_ad0");
    wait_for(2, 1'b1, "mr_ad1");
    chk("mr_busy_pre", int'(busy), 1);
    @(negedge GCLK);
    reset = 1'b1;
    @(posedge GCLK); #1;
    chk_reset_state("midreset");
    @(negedge GCLK);
    reset = 1'b0;

    run_round(8'h40, 8'h33);
    chk("prime_valid", int'(pos_if.pos_valid), 1);
    chk("prime_dx", int'(pos_if.delta_x), 0);
    chk("prime_px", int'(pos_if.pos_x), 639);
    chk("prime_py", int'(pos_if.pos_y), 511);
    accept("prime_drop");

    run_round(8'h42, 8'h30);
    chk("post_dx", int'(pos_if.delta_x), 2);
    chk("post_dy", int'(pos_if.delta_y), 8'hFD);
    chk("post_px", int'(pos_if.pos_x), 655);
    chk("post_py", int'(pos_if.pos_y), 499);
    accept("post_drop");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
